fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage for the MIPS core. It holds the program counter, drives a word-aligned byte address into the combinational instruction memory, and latches the returned word into the IF/ID pipeline register consumed by the decoder. The stage supports hazard-unit stalls and taken-branch/jump redirects from downstream, with a bubble injected on every redirect.

## Interface

- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word aligned.
- `NOP_INST`, default 32'h0000_0000: instruction word placed in IF/ID on reset and on flush.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_addr` output 32: byte fetch address; always equal to the current PC.
- `imem_data` input 32: instruction word returned combinationally for `imem_addr`.
- `stall` input 1: hazard unit request to hold the PC and IF/ID.
- `redirect_valid` input 1: taken branch or jump resolved downstream.
- `redirect_target` input 32: new PC when `redirect_valid` is high.
- `if_id_inst` output 32: latched instruction.
- `if_id_pc` output 32: PC of the latched instruction.
- `if_id_pc_plus4` output 32: `if_id_pc + 4`, modulo 2^32.
- `if_id_valid` output 1: IF/ID holds a real instruction, not a bubble.
- `misalign_err` output 1: sticky flag, set when a redirect target has nonzero bits [1:0].

## Operation

- **PC update (priority order):**
  - `rst`: PC = `RESET_PC`.
  - `redirect_valid`: PC = {`redirect_target`[31:2], 2'b00}.
  - `stall`: PC holds.
  - Otherwise: PC = PC + 4. Wraps from 32'hFFFF_FFFC to 32'h0 with no flag.
- **IF/ID update (same priority):**
  - `rst`: inst = `NOP_INST`, pc = `RESET_PC`, pc_plus4 = `RESET_PC`+4, valid = 0.
  - `redirect_valid`: inst = `NOP_INST`, valid = 0. pc and pc_plus4 hold. The word being fetched that cycle is discarded.
  - `stall`: all IF/ID fields hold.
  - Otherwise: inst = `imem_data`, pc = PC, pc_plus4 = PC+4, valid = 1.
- **Simultaneous `redirect_valid` and `stall`:** redirect wins. The PC is retargeted and a bubble is written. A stalled decoder must not depend on IF/ID contents when a redirect is present.
- **`misalign_err`:** set on any accepted redirect whose target bits [1:0] are nonzero. Cleared only by `rst`. The fetch itself proceeds at the aligned address.
- **Reset mid-stream:** `rst` overrides all other inputs in the same cycle. In-flight IF/ID contents are lost.
- `imem_addr` is purely `PC`; it has no combinational path from `stall` or `redirect_*`.

## Timing

- **Reset outputs:** `imem_addr` = `RESET_PC`, `if_id_valid` = 0, `if_id_inst` = `NOP_INST`, `misalign_err` = 0.
- **First valid instruction:** appears in IF/ID on the first rising edge after `rst` deasserts. Fetch-to-IF/ID latency is one cycle.
- **Redirect:** asserting `redirect_valid` in cycle N gives `imem_addr` = target in cycle N+1, a bubble in IF/ID during N+1, and the target instruction valid in IF/ID at N+2. Redirect penalty is one bubble.
- **Stall:** asserting `stall` for k cycles holds the PC and IF/ID for exactly k cycles. No instruction is lost or duplicated.
- Sustained throughput is one instruction per cycle absent stalls and redirects.

## Structure

- Shared package `mips_pkg`: `NOP_INST`, `RESET_PC`, and the instruction-width constant (32). The decoder reuses the same package.
- Sub-module `pc_reg`: PC register with next-PC mux (reset / redirect / stall / increment). Instantiated once.
- IF/ID register and `misalign_err` live in the top level.

## Test plan

- **Reset then free-run:** assert `rst` 2 cycles, then release. `imem_addr` sequence is 0, 4, 8, 12. IF/ID carries word@0 (pc 0, pc_plus4 4, valid 1) one cycle after release, then word@4.
- **Stall:** assert `stall` for 3 cycles with PC=8. `imem_addr` stays 8 and IF/ID stays constant for 3 cycles. The next edge latches word@8; no skipped or repeated PCs.
- **Redirect:** `redirect_valid`=1 with target 32'h40 while PC=12. Next cycle: `imem_addr`=32'h40 and `if_id_valid`=0. Following cycle: `if_id_pc`=32'h40 and valid=1.
- **Redirect plus stall:** assert both with target 32'h20. PC becomes 32'h20 and a bubble is written; stall is ignored that cycle.
- **Misaligned target:** target 32'h0000_0046. `imem_addr`=32'h44 and `misalign_err`=1, which stays set until `rst`.
- **Wrap-around and mid-run reset:** with `RESET_PC`=32'hFFFF_FFF8 and free-run, addresses are FFFF_FFF8, FFFF_FFFC, 0. Asserting `rst` mid-stream returns `imem_addr` to `RESET_PC` and `if_id_valid` to 0 on the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Constants and helpers shared by the fetch stage and decoder.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 32;

    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0000;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_reg
//  Purpose  : Program counter with reset / redirect / stall / increment mux.
//  Revision : 1.0  initial release
// ============================================================================
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [ADDR_WIDTH-1:0] r_pc;

    // Redirect outranks stall so a resolved branch is never lost behind a hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= word_align(redirect_target);
        end else if (!stall) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch: PC, instruction-memory address, IF/ID register.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [INST_WIDTH-1:0] NOP_INST = mips_pkg::NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_data,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [INST_WIDTH-1:0] if_id_inst,
    output logic [ADDR_WIDTH-1:0] if_id_pc,
    output logic [ADDR_WIDTH-1:0] if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic                  misalign_err
);

    logic [ADDR_WIDTH-1:0] w_pc;
    logic [INST_WIDTH-1:0] r_inst;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_pc_plus4;
    logic                  r_valid;
    logic                  r_misalign;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (w_pc)
    );

    // The address comes straight from the PC flop, never from the control inputs.
    assign imem_addr = w_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst     <= NOP_INST;
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC + 32'd4;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else if (redirect_valid) begin
            // Squash the wrong-path word; pc fields keep their last values.
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
            if (is_misaligned(redirect_target)) begin
                r_misalign <= 1'b1;
            end
        end else if (!stall) begin
            r_inst     <= imem_data;
            r_pc       <= w_pc;
            r_pc_plus4 <= w_pc + 32'd4;
            r_valid    <= 1'b1;
        end
    end

    assign if_id_inst     = r_inst;
    assign if_id_pc       = r_pc;
    assign if_id_pc_plus4 = r_pc_plus4;
    assign if_id_valid    = r_valid;
    assign misalign_err   = r_misalign;

endmodule
`default_nettype wire
